zigbee_phy_framer: RTL
======================

Name: zigbee_phy_framer

Overview:
Transmit-side PHY framer that sits directly upstream of the inFIFO.
- Takes a PSDU length and payload bytes from the host/MAC.
- Builds the 802.15.4 PPDU: preamble, SFD 0xA7, PHR, payload and optional FCS.
- Emits it as 4-bit nibbles with a write strobe into the inFIFO's 4-bit data port, which feeds the MSK modulator.
- Nibble order on air is low nibble first within every byte.

Parameters:
PREAMBLE_NIBBLES, 8, number of 0x0 nibbles sent before SFD (8 = 4 zero bytes).
MAX_PSDU, 127, largest legal PHR value.

Ports:
inClock  in  1  system clock
inReset  in  1  asynchronous, active-high reset
inStart  in  1  one-cycle request to begin a frame; sampled only in IDLE
inLength  in  7  number of host payload bytes for this frame, sampled with inStart
inByte  in  8  payload byte from host
inByteValid  in  1  inByte valid
outByteReady  out  1  framer accepts inByte this cycle (transfer = inByteValid & outByteReady)
inFifoFull  in  1  inFIFO full; blocks nibble writes
outData  out  4  nibble to inFIFO
outWriteEnable  out  1  write strobe to inFIFO; one nibble per asserted cycle
outBusy  out  1  frame in progress
outDone  out  1  one-cycle pulse after last nibble written
outError  out  1  one-cycle pulse: illegal length rejected

Behaviour:
Reset (asynchronous, active-high, any time including mid-frame):
- All outputs go to 0, FSM goes to IDLE, counters, byte buffer and CRC clear.
- No partial frame resumes after reset.

States and transitions: IDLE -> PREAMBLE -> SFD -> PHR -> PAYLOAD -> FCS -> IDLE.
- IDLE, inStart=1: compute PHR = inLength (no FCS) or inLength+2 (FCS).
  - If PHR > MAX_PSDU: pulse outError next cycle and stay in IDLE.
  - Otherwise latch PHR and go to PREAMBLE. outBusy=1 from the next cycle until outDone.
- PREAMBLE: PREAMBLE_NIBBLES writes of 0x0.
- SFD: writes 0x7, then 0xA.
- PHR: writes PHR[3:0], then {1'b0, PHR[6:4]}.
- PAYLOAD: repeats inLength times.
  - One-byte buffer; outByteReady=1 only while in PAYLOAD, buffer empty and bytes remain.
  - An accepted byte emits low nibble, then high nibble; the buffer empties after the high-nibble write.
  - Peak throughput is one byte per 2 cycles. A transfer can happen in the same cycle the high nibble is written.
  - Host underrun: no write, wait indefinitely.
  - inLength=0: skip PAYLOAD.
- FCS: only with the feature; otherwise go straight to IDLE.
- Final write: outDone pulses on the cycle after the final write, together with outBusy falling.

Write rule (all states):
- outWriteEnable = 1 iff a nibble is pending and inFifoFull = 0.
- While full, outData holds and the sequence position does not advance.
- No nibble is dropped or duplicated.

Other rules:
- outData is registered; outWriteEnable is registered from the pending & ~inFifoFull term of the same cycle.
- inStart while busy: ignored, no error.
- inByteValid outside PAYLOAD: ignored, outByteReady=0.
- Extra host bytes are never accepted.

Optional Feature:
ZIGBEE_FCS_EN defined:
- Appends a 2-byte FCS: CRC-16 ITU-T, poly x^16+x^12+x^5+1, init 0x0000, computed over payload bytes only, bit-serial LSB-first (reflected poly 0x8408).
- Updated nibble-wise as each payload nibble is written.
- Sent FCS[7:0] then FCS[15:8], each low nibble first (4 writes).
- PHR = inLength+2; inLength > 125 triggers outError.

ZIGBEE_FCS_EN undefined:
- No CRC logic and no FCS state; PHR = inLength.
- inLength 0..127 is legal, so outError is never asserted (tied 0).

Decomposition:
Package zigbee_pkg:
- SFD_BYTE = 8'hA7.
- MAX_PSDU_LEN = 127.
- FCS_POLY_REFL = 16'h8408.
- Framer state enum typedef: IDLE, PREAMBLE, SFD, PHR, PAYLOAD, FCS.
- Nibble typedef logic [3:0].

Sub-module zigbee_fcs_crc16:
- Inputs: clock, reset, clear, enable, nibble.
- Output: 16-bit CRC.
- Combinational 4-step update with the CRC register inside.
- Instantiated only under ZIGBEE_FCS_EN.

Test Plan:
1. No FCS, inStart with inLength=1, byte 0x5A, inFifoFull=0 -> 14 writes: eight 0x0, then 7, A, 1, 0, A, 5. outDone pulses one cycle after the last write; outBusy then falls.
2. Same as 1 with inFifoFull high 3 cycles during preamble and 2 cycles between the payload nibbles -> identical 14-nibble sequence, no write while full, outData stable while full.
3. FCS_EN, inLength=1, byte 0x01 -> after preamble: 7, A, 3, 0, 1, 0, 9, 8, 1, 1 (FCS=0x1189).
4. FCS_EN, inLength=0 -> preamble, 7, A, 2, 0, then 0, 0, 0, 0; outByteReady never asserted.
5. FCS_EN inLength=126, and non-FCS inLength=127 -> FCS case: outError pulse, zero writes, outBusy stays 0. Non-FCS case: accepted with PHR nibbles F, 7. A second inStart mid-frame is ignored.
6. inReset asserted mid-PAYLOAD with byte buffer full -> all outputs 0 immediately. After release, a new 1-byte frame reproduces scenario 1 exactly.

Source files
------------

// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 transmit PHY framer.
// Contents: SFD byte, maximum PSDU length, reflected CRC-16 polynomial,
// framer state enum, nibble type, and a 4-bit CRC step used by the FCS block.
package zigbee_pkg;
  localparam logic [7:0]  SFD_BYTE      = 8'hA7;
  localparam int          MAX_PSDU_LEN  = 127;
  localparam logic [15:0] FCS_POLY_REFL = 16'h8408;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PHR, PAYLOAD, FCS} state_t;
  typedef logic [3:0] nibble_t;

  // Four LSB-first bit steps of CRC-16 ITU-T (reflected form).
  function automatic logic [15:0] crc16_nibble(input logic [15:0] c, input nibble_t n);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 4; i++)
      r = (r >> 1) ^ (((r[0] ^ n[i]) != 1'b0) ? FCS_POLY_REFL : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/zigbee_phy_framer_if.sv
// Host and inFIFO handshake bundle for zigbee_phy_framer.
//   inStart/inLength      : frame request and payload byte count
//   inByte/inByteValid    : host payload stream, outByteReady accepts it
//   inFifoFull            : inFIFO back-pressure
//   outData/outWriteEnable: nibble write port into the inFIFO
//   outBusy/outDone/outError : frame status
// master = host/FIFO side, slave = framer.
interface zigbee_phy_framer_if;
  import zigbee_pkg::*;
  logic       inStart;
  logic [6:0] inLength;
  logic [7:0] inByte;
  logic       inByteValid;
  logic       outByteReady;
  logic       inFifoFull;
  nibble_t    outData;
  logic       outWriteEnable;
  logic       outBusy;
  logic       outDone;
  logic       outError;

  modport master (
    output inStart, inLength, inByte, inByteValid, inFifoFull,
    input  outByteReady, outData, outWriteEnable, outBusy, outDone, outError
  );
  modport slave (
    input  inStart, inLength, inByte, inByteValid, inFifoFull,
    output outByteReady, outData, outWriteEnable, outBusy, outDone, outError
  );
endinterface

// File: rtl/zigbee_fcs_crc16.sv
// CRC-16 ITU-T accumulator (init 0, reflected poly 0x8408), advanced one
// payload nibble per enabled cycle, low nibble of each byte first.
// Ports: clock, reset (async high), clear (sync), enable, nibble in, crc out.
module zigbee_fcs_crc16
  import zigbee_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  nibble_t     nibble,
  output logic [15:0] crc
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= crc16_nibble(crc, nibble);
  end
endmodule

// File: rtl/zigbee_phy_framer.sv
// 802.15.4 transmit framer: preamble, SFD, PHR, payload and optional FCS,
// written as low-nibble-first nibbles into the inFIFO.
// Ports: inClock, inReset (async active-high), bus (zigbee_phy_framer_if.slave).
// Build option: define ZIGBEE_FCS_EN to append the 2-byte CRC-16 FCS
// (PHR = length + 2, lengths above 125 rejected with outError).
module zigbee_phy_framer
  import zigbee_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 8,
  parameter int MAX_PSDU         = MAX_PSDU_LEN
) (
  input logic                inClock,
  input logic                inReset,
  zigbee_phy_framer_if.slave bus
);
`ifdef ZIGBEE_FCS_EN
  localparam logic [7:0] PHR_EXTRA = 8'd2;
`else
  localparam logic [7:0] PHR_EXTRA = 8'd0;
`endif

  state_t     state, state_n;
  logic [7:0] cnt;        // nibble position inside the current state
  logic [6:0] phr;
  logic [6:0] rem;        // payload bytes not yet accepted from the host
  logic [7:0] byte_buf;
  logic       buf_full, hi;
  logic       busy_q, last_q, done_q, we_q;
  nibble_t    data_q, nib;
  logic       pend, go, ready, accept, start_ok, last_nib, end_body;
  logic [7:0] phr_calc;

`ifdef ZIGBEE_FCS_EN
  logic [15:0] crc;
  logic        err_q;

  zigbee_fcs_crc16 u_crc (
    .clock  (inClock),
    .reset  (inReset),
    .clear  (start_ok),
    .enable (go && (state == PAYLOAD)),
    .nibble (nib),
    .crc    (crc)
  );
`endif

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    nib      = '0;
    pend     = 1'b0;
    last_nib = 1'b0;
    end_body = 1'b0;
    phr_calc = {1'b0, bus.inLength} + PHR_EXTRA;
    // busy_q stays high through the final write cycle, so a start cannot
    // slip in before outDone.
    start_ok = (state == IDLE) && !busy_q && bus.inStart && (phr_calc <= 8'(MAX_PSDU));
    unique case (state)
      IDLE:     if (start_ok) state_n = PREAMBLE;
      PREAMBLE: pend = 1'b1;
      SFD: begin
        pend = 1'b1;
        nib  = cnt[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
      end
      PHR: begin
        pend = 1'b1;
        nib  = cnt[0] ? {1'b0, phr[6:4]} : phr[3:0];
      end
      PAYLOAD: begin
        pend = buf_full;
        nib  = hi ? byte_buf[7:4] : byte_buf[3:0];
      end
`ifdef ZIGBEE_FCS_EN
      FCS: begin
        pend = 1'b1;
        unique case (cnt[1:0])
          2'd0: nib = crc[3:0];
          2'd1: nib = crc[7:4];
          2'd2: nib = crc[11:8];
          default: nib = crc[15:12];
        endcase
      end
`endif
      default: state_n = IDLE;
    endcase

    go     = pend && !bus.inFifoFull;
    // The buffer can refill in the same cycle its high nibble goes out.
    ready  = (state == PAYLOAD) && (rem != 7'd0) && (!buf_full || (hi && go));
    accept = ready && bus.inByteValid;

    if (go) begin
      unique case (state)
        PREAMBLE: if (cnt == 8'(PREAMBLE_NIBBLES - 1)) state_n = SFD;
        SFD:      if (cnt[0]) state_n = PHR;
        PHR: if (cnt[0]) begin
          if (rem != 7'd0) state_n = PAYLOAD;
          else             end_body = 1'b1;
        end
        PAYLOAD: if (hi && (rem == 7'd0)) end_body = 1'b1;
`ifdef ZIGBEE_FCS_EN
        FCS: if (cnt[1:0] == 2'd3) begin
          state_n  = IDLE;
          last_nib = 1'b1;
        end
`endif
        default: ;
      endcase
    end

    if (end_body) begin
`ifdef ZIGBEE_FCS_EN
      state_n = FCS;
`else
      state_n  = IDLE;
      last_nib = 1'b1;
`endif
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      cnt      <= '0;
      phr      <= '0;
      rem      <= '0;
      byte_buf <= '0;
      buf_full <= 1'b0;
      hi       <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      if (state_n != state) cnt <= '0;
      else if (go)          cnt <= cnt + 8'd1;

      we_q <= go;
      if (go) data_q <= nib;

      // outDone/outBusy-fall land one cycle after the final strobe.
      last_q <= last_nib;
      done_q <= last_q;
      if (last_q)   busy_q <= 1'b0;
      if (start_ok) busy_q <= 1'b1;

      if (start_ok) begin
        phr      <= phr_calc[6:0];
        rem      <= bus.inLength;
        buf_full <= 1'b0;
        hi       <= 1'b0;
      end
      if ((state == PAYLOAD) && go) begin
        if (hi) begin
          hi       <= 1'b0;
          buf_full <= 1'b0;
        end else begin
          hi <= 1'b1;
        end
      end
      if (accept) begin
        byte_buf <= bus.inByte;
        buf_full <= 1'b1;
        hi       <= 1'b0;
        rem      <= rem - 7'd1;
      end
    end
  end

`ifdef ZIGBEE_FCS_EN
  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) err_q <= 1'b0;
    else         err_q <= (state == IDLE) && !busy_q && bus.inStart && (phr_calc > 8'(MAX_PSDU));
  end
  assign bus.outError = err_q;
`else
  assign bus.outError = 1'b0;
`endif

  assign bus.outByteReady   = ready;
  assign bus.outData        = data_q;
  assign bus.outWriteEnable = we_q;
  assign bus.outBusy        = busy_q;
  assign bus.outDone        = done_q;
endmodule
